glitch_sequencer: RTL
=====================

Name: glitch_sequencer

Overview:
- Programmable glitch-pulse scheduler in the 100 MHz sysclk domain; drives the board glitch output.
- The UART command decoder loads timing registers and arms the block. A synchronized external trigger edge then starts a sequence: delay, then COUNT pulses of WIDTH cycles separated by GAP cycles.
- Makes the glitch output cycle-exact relative to the trigger; single-shot or auto-rearm.

Parameters:
- CNT_W, 32, width of delay/width/gap/count/timeout registers and counters.
- SYNC_STAGES, 2, trigger synchronizer depth (>=2).

Ports:
- clk  input  1  100 MHz sysclk.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- i_cfg_we  input  1  config write strobe, one cycle.
- i_cfg_addr  input  3  register select: 0 DELAY, 1 WIDTH, 2 GAP, 3 COUNT, 4 CTRL, 5 TIMEOUT.
- i_cfg_data  input  CNT_W  write data.
- i_arm  input  1  arm strobe, one cycle.
- i_disarm  input  1  abort/disarm strobe, one cycle.
- i_trig  input  1  asynchronous external trigger.
- o_glitch  output  1  registered glitch pulse.
- o_armed  output  1  high in ARMED.
- o_busy  output  1  high in DELAY/PULSE/GAP.
- o_done  output  1  one-cycle strobe at sequence end.
- o_timeout  output  1  one-cycle strobe on arm timeout.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Shadow registers: DELAY=0, WIDTH=1, GAP=1, COUNT=1, CTRL=0, TIMEOUT=0.
- Config writes:
  - i_cfg_we writes the shadow register at i_cfg_addr; addresses 6-7 are ignored.
  - Writes are accepted in any state.
  - The active copies are loaded from the shadows only on an accepted arm, so a running sequence is never altered.
- CTRL bits:
  - bit0 REARM: after DONE, return to ARMED instead of IDLE.
  - bit1 POL: 1 = trigger on falling edge, 0 = rising edge.
- Trigger path:
  - i_trig passes through SYNC_STAGES flops, then an edge-detect register.
  - Edge event = sync_out != prev and sync_out matches POL.
  - Trigger events outside ARMED are ignored.
- Zero-value clamping: WIDTH, GAP and COUNT of 0 are treated as 1. DELAY=0 is legal.
- States:
  - IDLE:
    - i_arm (without i_disarm) -> load active copies -> ARMED.
  - ARMED:
    - On a trigger event -> DELAY, with dcnt=DELAY and pcnt=COUNT.
    - Call the cycle in which the state becomes DELAY "T".
  - DELAY:
    - dcnt==0 -> PULSE with wcnt=WIDTH; otherwise decrement.
    - o_glitch first reads 1 in cycle T+DELAY+1.
  - PULSE:
    - o_glitch=1 for exactly WIDTH cycles.
    - At the end: if pcnt==1 -> DONE; otherwise decrement pcnt and go to GAP with gcnt=GAP.
  - GAP:
    - o_glitch=0 for exactly GAP cycles, then PULSE.
  - DONE (one cycle):
    - o_done=1.
    - Next state: ARMED if REARM, else IDLE.
    - Under REARM the active values are retained and not reloaded from the shadows.
- o_glitch is a registered decode of state==PULSE.
- Priority and boundary conditions:
  - i_disarm in any state -> IDLE next cycle; o_glitch 0 the next cycle.
  - Simultaneous i_arm and i_disarm: disarm wins.
  - i_arm outside IDLE is ignored.
  - A trigger event in the same cycle as disarm is ignored.
  - Trigger edges during DELAY/PULSE/GAP/DONE are dropped, not queued.
  - Counter arithmetic is unsigned CNT_W; counters decrement only, so there is no wrap. DELAY=2^CNT_W-1 is legal.
  - Reset asserted mid-pulse drops o_glitch asynchronously.
- o_armed = (state==ARMED). o_busy = state in {DELAY, PULSE, GAP}.

Optional Feature:
- Macro: GLITCH_ARM_TIMEOUT_EN.
- Defined:
  - Entering ARMED loads tcnt=TIMEOUT.
  - If TIMEOUT != 0 and tcnt reaches 0 with no trigger event -> IDLE, with o_timeout=1 for one cycle.
  - TIMEOUT=0 disables the timeout.
  - A trigger in the same cycle as expiry wins: sequence starts, no o_timeout.
- Not defined:
  - Address 5 writes are ignored.
  - o_timeout tied 0.
  - ARMED waits indefinitely.

Test Plan:
- Basic timing:
  - Stimulus: DELAY=10, WIDTH=3, COUNT=1; arm; rising i_trig.
  - Response: o_glitch high cycles T+11..T+13; o_done at T+14; o_armed 0 after.
- Pulse train:
  - Stimulus: DELAY=0, WIDTH=2, GAP=4, COUNT=3.
  - Response: glitch high at T+1..T+2, T+7..T+8, T+13..T+14; exactly 3 pulses; one o_done.
- Clamping and polarity:
  - Stimulus: WIDTH=0, GAP=0, COUNT=0, POL=1; rising edge, then falling edge.
  - Response: rising edge ignored; falling edge gives a single 1-cycle pulse.
- Abort and arm priority:
  - Stimulus: disarm mid-PULSE of WIDTH=100.
  - Response: o_glitch low the next cycle; state IDLE; no o_done.
  - Stimulus: arm+disarm in the same cycle.
  - Response: stays IDLE.
- Rearm and shadowing:
  - Stimulus: REARM=1, WIDTH=5. Write WIDTH=9 while busy; send a second trigger.
  - Response: second sequence still uses WIDTH=5. Extra trigger during PULSE is dropped.
- Timeout (GLITCH_ARM_TIMEOUT_EN defined):
  - Stimulus: TIMEOUT=50; arm; no trigger.
  - Response: o_timeout at ARMED-entry+51; state IDLE.
- Asynchronous reset:
  - Stimulus: assert reset mid-GAP.
  - Response: all outputs 0 immediately.

Source files
------------

// File: rtl/glitch_sequencer.sv
// glitch_sequencer
//   Programmable glitch-pulse scheduler. Timing registers are written into
//   shadow copies at any time and copied to the active set on an accepted arm.
//   A synchronized trigger edge in ARMED starts: DELAY cycles of wait, then
//   COUNT pulses of WIDTH cycles separated by GAP cycles, then a DONE strobe.
//
// Optional feature macro: GLITCH_ARM_TIMEOUT_EN
//   Defined:   ARMED gives up after TIMEOUT cycles without a trigger event
//              (o_timeout strobe, back to IDLE). TIMEOUT=0 disables it.
//   Undefined: address 5 is ignored, o_timeout is tied low.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-high reset
//   i_cfg_we     config write strobe
//   i_cfg_addr   0 DELAY, 1 WIDTH, 2 GAP, 3 COUNT, 4 CTRL{pol,rearm}, 5 TIMEOUT
//   i_cfg_data   config write data
//   i_arm        arm strobe (accepted only in IDLE)
//   i_disarm     abort strobe, wins over everything
//   i_trig       asynchronous external trigger
//   o_glitch     registered glitch pulse
//   o_armed      high in ARMED
//   o_busy       high in DELAY/PULSE/GAP
//   o_done       one-cycle strobe at sequence end
//   o_timeout    one-cycle strobe on arm timeout
module glitch_sequencer #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cfg_we,
  input  logic [2:0]       i_cfg_addr,
  input  logic [CNT_W-1:0] i_cfg_data,
  input  logic             i_arm,
  input  logic             i_disarm,
  input  logic             i_trig,
  output logic             o_glitch,
  output logic             o_armed,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DELAY, S_PULSE, S_GAP, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // WIDTH/GAP/COUNT of zero behave as one.
  function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  state_t state_q, state_d;
  logic   load_active;
  logic   timeout_fire;

  logic [CNT_W-1:0] sh_delay, sh_width, sh_gap, sh_count;
  logic [1:0]       sh_ctrl;
  logic [CNT_W-1:0] act_delay, act_width, act_gap, act_count;
  logic             act_rearm, act_pol;
  logic [CNT_W-1:0] dcnt, wcnt, gcnt, pcnt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   trig_prev;
  logic                   sync_out;
  logic                   trig_event;

  // Shadow registers: writable in any state, never used directly by a sequence.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_delay <= '0;
      sh_width <= ONE;
      sh_gap   <= ONE;
      sh_count <= ONE;
      sh_ctrl  <= '0;
    end else if (i_cfg_we) begin
      case (i_cfg_addr)
        3'd0:    sh_delay <= i_cfg_data;
        3'd1:    sh_width <= i_cfg_data;
        3'd2:    sh_gap   <= i_cfg_data;
        3'd3:    sh_count <= i_cfg_data;
        3'd4:    sh_ctrl  <= i_cfg_data[1:0];
        default: ;
      endcase
    end
  end

  // Trigger synchronizer plus one edge-detect register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      trig_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], i_trig};
      trig_prev <= sync_out;
    end
  end

  assign sync_out   = sync_q[SYNC_STAGES-1];
  // POL=0 selects rising edges (new level 1), POL=1 falling (new level 0).
  assign trig_event = (sync_out != trig_prev) && (sync_out == ~act_pol);

`ifdef GLITCH_ARM_TIMEOUT_EN
  logic [CNT_W-1:0] sh_timeout, act_timeout, tcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_timeout  <= '0;
      act_timeout <= '0;
      tcnt        <= '0;
    end else begin
      if (i_cfg_we && i_cfg_addr == 3'd5) sh_timeout <= i_cfg_data;
      if (load_active) act_timeout <= sh_timeout;
      // Fresh count on every ARMED entry; from IDLE the active copy is being
      // loaded this same edge, so take the shadow directly.
      if (state_d == S_ARMED && state_q != S_ARMED)
        tcnt <= (state_q == S_IDLE) ? sh_timeout : act_timeout;
      else if (state_q == S_ARMED && tcnt != '0)
        tcnt <= tcnt - ONE;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    load_active  = 1'b0;
    timeout_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_arm) begin
          state_d     = S_ARMED;
          load_active = 1'b1;
        end
      end
      S_ARMED: begin
        if (trig_event) begin
          state_d = S_DELAY;
        end
`ifdef GLITCH_ARM_TIMEOUT_EN
        else if (act_timeout != '0 && tcnt == '0) begin
          state_d      = S_IDLE;
          timeout_fire = 1'b1;
        end
`endif
      end
      S_DELAY: if (dcnt == '0) state_d = S_PULSE;
      S_PULSE: if (wcnt == ONE) state_d = (pcnt == ONE) ? S_DONE : S_GAP;
      S_GAP:   if (gcnt == ONE) state_d = S_PULSE;
      S_DONE:  state_d = act_rearm ? S_ARMED : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Disarm overrides arm, trigger and timeout alike.
    if (i_disarm) begin
      state_d      = S_IDLE;
      load_active  = 1'b0;
      timeout_fire = 1'b0;
    end
  end

  // Active copies and sequence counters. wcnt/gcnt count down to 1 so the
  // state lasts exactly WIDTH/GAP cycles; dcnt counts to 0 so DELAY=0 works.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_delay <= '0;
      act_width <= ONE;
      act_gap   <= ONE;
      act_count <= ONE;
      act_rearm <= 1'b0;
      act_pol   <= 1'b0;
      dcnt      <= '0;
      wcnt      <= '0;
      gcnt      <= '0;
      pcnt      <= '0;
    end else begin
      if (load_active) begin
        act_delay <= sh_delay;
        act_width <= clamp1(sh_width);
        act_gap   <= clamp1(sh_gap);
        act_count <= clamp1(sh_count);
        act_rearm <= sh_ctrl[0];
        act_pol   <= sh_ctrl[1];
      end
      case (state_q)
        S_ARMED: begin
          if (state_d == S_DELAY) begin
            dcnt <= act_delay;
            pcnt <= act_count;
          end
        end
        S_DELAY: begin
          if (dcnt != '0) dcnt <= dcnt - ONE;
          else            wcnt <= act_width;
        end
        S_PULSE: begin
          if (state_d == S_GAP) begin
            gcnt <= act_gap;
            pcnt <= pcnt - ONE;
          end else begin
            wcnt <= wcnt - ONE;
          end
        end
        S_GAP: begin
          if (gcnt == ONE) wcnt <= act_width;
          else             gcnt <= gcnt - ONE;
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered decodes of the next state so they line up with
  // the state register and are glitch-free at the pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_glitch  <= 1'b0;
      o_armed   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_glitch  <= (state_d == S_PULSE);
      o_armed   <= (state_d == S_ARMED);
      o_busy    <= (state_d == S_DELAY) || (state_d == S_PULSE) || (state_d == S_GAP);
      o_done    <= (state_d == S_DONE);
      o_timeout <= timeout_fire;
    end
  end

endmodule
